datamem_seq: RTL and testbench
==============================

Name: datamem_seq

Overview:
- Multi-cycle access sequencer between the CPU load/store stage and the byte-wide data memory.
- The memory stores 8 bits per address, has a combinational read and a write on the clock edge; it natively supports only byte access.
- This block splits half-word and word loads/stores into consecutive byte accesses, little-endian.
- It stalls the pipeline while a transfer is in progress and reports out-of-range or illegal requests.

Parameters:
- ADDR_WIDTH, 32, width of the CPU address and the memory address.
- DATA_WIDTH, 32, width of CPU write data and read data.
- ADDR_LIMIT, 32'h0001FFFF, highest legal byte address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  CPU access request; held high until done.
- we  in  1  1 = store, 0 = load; sampled at acceptance.
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal; sampled at acceptance.
- uns  in  1  1 = zero-extend load, 0 = sign-extend load.
- addr  in  ADDR_WIDTH  base byte address; no alignment requirement.
- wdata  in  DATA_WIDTH  store data; byte k is written to addr+k.
- rdata  out  DATA_WIDTH  extended load result; valid only while done=1.
- stall  out  1  = req & ~done (combinational); freezes the pipeline.
- done  out  1  one-cycle completion pulse.
- err  out  1  pulses with done for an illegal size or an out-of-range address.
- mem_a  out  ADDR_WIDTH  memory address.
- mem_wd  out  DATA_WIDTH  memory write data; byte in [7:0], upper bits 0.
- mem_we  out  1  memory write enable.
- mem_rd  in  DATA_WIDTH  memory read data; only [7:0] is used.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, all captured registers cleared. done, err, mem_we, mem_a, mem_wd, rdata all 0.
- mem_we is decoded from state, so asserting reset mid-store removes the write enable immediately. No partial-transfer rollback: bytes already written stay written.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - When req=1: capture we, size, uns, addr, wdata; nbytes = 1, 2 or 4; cnt=0.
  - Error check: size=11, or addr+nbytes-1 > ADDR_LIMIT, or the 33-bit sum overflows. On error, go directly to DONE with the err flag set; no memory access occurs.
  - Otherwise go to ACCESS.
- ACCESS (one cycle per byte):
  - mem_a = base+cnt.
  - Store: mem_we=1, mem_wd = {24'b0, wdata byte cnt}.
  - Load: mem_we=0; on the edge, buffer byte lane cnt <= mem_rd[7:0].
  - cnt increments each cycle. When cnt = nbytes-1, go to DONE.
- DONE (exactly one cycle): done=1, err as flagged; then return to IDLE.
- rdata in DONE:
  - Byte load: bit 7 replicated, or zeros if uns=1.
  - Half load: bit 15 replicated, or zeros if uns=1.
  - Word load: raw buffer.
  - Store or error: 0.
- Latency, from the acceptance edge to the done cycle:
  - byte: 2 cycles
  - half: 3 cycles
  - word: 5 cycles
  - error: 1 cycle
- A request is accepted only in IDLE. If req is still high in the DONE cycle, it is treated as a new request on the following IDLE cycle; the CPU must drop req or advance after done.
- Inputs are captured at acceptance. If req drops or inputs change mid-transfer, the transfer still completes atomically.
- Outside ACCESS, mem_a and mem_wd are 0.

Decomposition:
- Package datamem_seq_pkg:
  - size_t enum: SZ_B, SZ_H, SZ_W, SZ_ILL.
  - state_t enum: IDLE, ACCESS, DONE.
  - Function nbytes(size_t).
  - Constant DEFAULT_ADDR_LIMIT.
- One sub-module, load_ext: combinational extension from the buffer, size and uns to rdata. It is reused by later cache work.

Test Plan:
- Word store of 32'hDEADBEEF to 0x10000, then a word load from 0x10000 -> four mem_we cycles with mem_wd[7:0] = EF, BE, AD, DE at 0x10000..0x10003; the load returns rdata=32'hDEADBEEF, with done on the 5th cycle after acceptance and stall high until then.
- Signed byte load of 0x80 at 0x10004 -> rdata=32'hFFFFFF80; with uns=1 -> 32'h00000080; done two cycles after acceptance.
- Misaligned half store of 16'h8001 at 0x10005, then a signed half load -> bytes 0x01@0x10005 and 0x80@0x10006; rdata=32'hFFFF8001.
- Word access at 0x1FFFE (crosses ADDR_LIMIT) and size=11 -> done and err pulse one cycle after acceptance, mem_we never asserted, rdata=0.
- Assert rst_n=0 during the second byte of a word store -> mem_we falls in the same cycle, FSM returns to IDLE; the first byte stays in memory, the second through fourth bytes are not written; the next request proceeds normally.
- Back-to-back byte loads with req held high -> second done three cycles after the first (DONE then IDLE acceptance); req dropped mid-word-load -> transfer still completes and done still pulses.

Source files
------------

// File: rtl/datamem_seq_pkg.sv
// Shared types and helpers for the byte-serial data memory sequencer.
// Access sizes, FSM states and the byte count per access size.
package datamem_seq_pkg;

  localparam logic [31:0] DEFAULT_ADDR_LIMIT = 32'h0001FFFF;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  // Illegal size reports one byte so the range check stays well defined.
  function automatic logic [2:0] nbytes(size_t s);
    case (s)
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/datamem_seq_if.sv
// CPU load/store bus plus byte-wide memory port of the sequencer.
// master = CPU/memory side, slave = sequencer.
interface datamem_seq_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [1:0]            size;
  logic                  uns;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  stall;
  logic                  done;
  logic                  err;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rd;

  modport master (
    output req, we, size, uns, addr, wdata, mem_rd,
    input  rdata, stall, done, err, mem_a, mem_wd, mem_we
  );

  modport slave (
    input  req, we, size, uns, addr, wdata, mem_rd,
    output rdata, stall, done, err, mem_a, mem_wd, mem_we
  );
endinterface

// File: rtl/datamem_seq_load_ext.sv
// Sign/zero extension of a little-endian load buffer to the CPU data width.
module load_ext
  import datamem_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] raw,
  input  size_t                 size,
  input  logic                  uns,
  output logic [DATA_WIDTH-1:0] ext
);

  always_comb begin
    ext = '0;
    case (size)
      SZ_B:    ext = {{(DATA_WIDTH-8){~uns & raw[7]}}, raw[7:0]};
      SZ_H:    ext = {{(DATA_WIDTH-16){~uns & raw[15]}}, raw[15:0]};
      SZ_W:    ext = raw;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/datamem_seq.sv
// Splits half/word loads and stores into little-endian byte accesses on a
// byte-wide memory, stalling the CPU until the transfer completes.
module datamem_seq
  import datamem_seq_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(DEFAULT_ADDR_LIMIT)
) (
  input logic          clk,
  input logic          rst_n,
  datamem_seq_if.slave bus
);

  localparam int NLANES = DATA_WIDTH / 8;

  state_t                state_reg, state_next;
  logic [1:0]            cnt_reg, cnt_next;
  logic                  we_reg, uns_reg, err_reg;
  size_t                 size_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [7:0]            lane_reg [NLANES];
  logic [DATA_WIDTH-1:0] buf_data, ext_data;

  size_t                 req_size;
  logic [ADDR_WIDTH:0]   end_addr;
  logic                  req_bad, accept, in_access, in_done;
  logic                  mem_rd_unused;

  assign req_size = size_t'(bus.size);
  // Carry out of the 33-bit sum catches wrap-around past the top of memory.
  assign end_addr = {1'b0, bus.addr} + {{(ADDR_WIDTH-2){1'b0}}, nbytes(req_size)}
                    - (ADDR_WIDTH+1)'(1);
  assign req_bad  = (req_size == SZ_ILL) || end_addr[ADDR_WIDTH]
                    || (end_addr[ADDR_WIDTH-1:0] > ADDR_LIMIT);
  assign accept   = (state_reg == IDLE) && bus.req;
  assign in_access = (state_reg == ACCESS);
  assign in_done   = (state_reg == DONE);
  assign mem_rd_unused = ^bus.mem_rd[DATA_WIDTH-1:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req) begin
          cnt_next   = '0;
          state_next = req_bad ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        cnt_next = cnt_reg + 2'd1;
        if ({1'b0, cnt_reg} == nbytes(size_reg) - 3'd1) state_next = DONE;
      end
      DONE: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg    <= 1'b0;
      uns_reg   <= 1'b0;
      err_reg   <= 1'b0;
      size_reg  <= SZ_B;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (accept) begin
      we_reg    <= bus.we;
      uns_reg   <= bus.uns;
      err_reg   <= req_bad;
      size_reg  <= req_size;
      addr_reg  <= bus.addr;
      wdata_reg <= bus.wdata;
    end
  end

  // Each byte lane of the load buffer fills on the ACCESS cycle of its offset.
  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_reg[gi] <= '0;
      end else if (in_access && !we_reg && (cnt_reg == 2'(gi))) begin
        lane_reg[gi] <= bus.mem_rd[7:0];
      end
    end
    assign buf_data[gi*8 +: 8] = lane_reg[gi];
  end

  load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
    .raw  (buf_data),
    .size (size_reg),
    .uns  (uns_reg),
    .ext  (ext_data)
  );

  // Memory strobes decode straight from state so reset drops them at once.
  always_comb begin
    bus.mem_a  = in_access ? addr_reg + {{(ADDR_WIDTH-2){1'b0}}, cnt_reg} : '0;
    bus.mem_wd = (in_access && we_reg)
                 ? {{(DATA_WIDTH-8){1'b0}}, wdata_reg[{cnt_reg, 3'b000} +: 8]} : '0;
    bus.mem_we = in_access && we_reg;
    bus.done   = in_done;
    bus.err    = in_done && err_reg;
    bus.rdata  = (in_done && !we_reg && !err_reg) ? ext_data : '0;
    bus.stall  = bus.req && !in_done;
  end

endmodule

// File: tb/tb_datamem_seq.sv
// Directed self-checking bench for datamem_seq against a byte-wide memory model.
module tb_datamem_seq;
  import datamem_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  datamem_seq_if bus ();

  datamem_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0]  mem [0:131071];
  logic [31:0] log_a [$];
  logic [7:0]  log_d [$];
  int checks = 0;
  int failures = 0;

  assign bus.mem_rd = {24'h0, mem[bus.mem_a[16:0]]};

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_a[16:0]] <= bus.mem_wd[7:0];
      log_a.push_back(bus.mem_a);
      log_d.push_back(bus.mem_wd[7:0]);
    end
  end

  // Issues one request at a negedge and waits (bounded) for done.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, input bit drop_mid,
                         output int lat, output logic [31:0] rd, output logic er,
                         output bit stall_ok);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.uns = u; bus.addr = a; bus.wdata = wd;
    lat = 0; rd = '0; er = 1'b0; stall_ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (drop_mid && i == 1) begin
        bus.req = 1'b0; bus.addr = 32'h0; bus.we = ~w; bus.size = 2'b00;
      end
      if (bus.done) begin
        lat = i; rd = bus.rdata; er = bus.err;
        break;
      end
      if (bus.stall !== bus.req) stall_ok = 1'b0;
    end
    bus.req = 1'b0;
    $display("txn we=%0b size=%0b uns=%0b addr=%h wdata=%h lat=%0d rdata=%h err=%0b",
             w, sz, u, a, wd, lat, rd, er);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.uns = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    #12;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", bus.err); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    checks++; if (bus.mem_a !== 32'h0) begin failures++; $display("FAIL reset_mem_a: got %h want 0", bus.mem_a); end
    checks++; if (bus.mem_wd !== 32'h0) begin failures++; $display("FAIL reset_mem_wd: got %h want 0", bus.mem_wd); end
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic er; bit sok;
    logic [7:0] exp_b [4];
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    log_a.delete(); log_d.delete();
    run_req(1'b1, 2'b10, 1'b0, 32'h0001_0000, 32'hDEADBEEF, 1'b0, lat, rd, er, sok);
    checks++; if (lat !== 5) begin failures++; $display("FAIL wst_latency: got %0d want 5", lat); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL wst_err: got %b want 0", er); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wst_rdata: got %h want 0", rd); end
    checks++; if (sok !== 1'b1) begin failures++; $display("FAIL wst_stall: got %b want 1", sok); end
    checks++; if (log_a.size() !== 4) begin failures++; $display("FAIL wst_nwrites: got %0d want 4", log_a.size()); end
    if (log_a.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (log_a[k] !== 32'h0001_0000 + k) begin failures++; $display("FAIL wst_addr%0d: got %h want %h", k, log_a[k], 32'h0001_0000 + k); end
        checks++; if (log_d[k] !== exp_b[k]) begin failures++; $display("FAIL wst_data%0d: got %h want %h", k, log_d[k], exp_b[k]); end
      end
    end
    log_a.delete(); log_d.delete();
    run_req(1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0, 1'b0, lat, rd, er, sok);
    checks++; if (lat !== 5) begin failures++; $display("FAIL wld_latency: got %0d want 5", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL wld_rdata: got %h want deadbeef", rd); end
    checks++; if (sok !== 1'b1) begin failures++; $display("FAIL wld_stall: got %b want 1", sok); end
    checks++; if (log_a.size() !== 0) begin failures++; $display("FAIL wld_nwrites: got %0d want 0", log_a.size()); end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic er; bit sok;
    mem[17'h10004] = 8'h80;
    run_req(1'b0, 2'b00, 1'b0, 32'h0001_0004, 32'h0, 1'b0, lat, rd, er, sok);
    checks++; if (lat !== 2) begin failures++; $display("FAIL bld_latency: got %0d want 2", lat); end
    checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL bld_signed: got %h want ffffff80", rd); end
    run_req(1'b0, 2'b00, 1'b1, 32'h0001_0004, 32'h0, 1'b0, lat, rd, er, sok);
    checks++; if (lat !== 2) begin failures++; $display("FAIL bldu_latency: got %0d want 2", lat); end
    checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL bld_unsigned: got %h want 00000080", rd); end
  endtask

  task automatic test_half();
    int lat; logic [31:0] rd; logic er; bit sok;
    log_a.delete(); log_d.delete();
    run_req(1'b1, 2'b01, 1'b0, 32'h0001_0005, 32'h1234_8001, 1'b0, lat, rd, er, sok);
    checks++; if (lat !== 3) begin failures++; $display("FAIL hst_latency: got %0d want 3", lat); end
    checks++; if (mem[17'h10005] !== 8'h01) begin failures++; $display("FAIL hst_byte0: got %h want 01", mem[17'h10005]); end
    checks++; if (mem[17'h10006] !== 8'h80) begin failures++; $display("FAIL hst_byte1: got %h want 80", mem[17'h10006]); end
    checks++; if (log_a.size() !== 2) begin failures++; $display("FAIL hst_nwrites: got %0d want 2", log_a.size()); end
    run_req(1'b0, 2'b01, 1'b0, 32'h0001_0005, 32'h0, 1'b0, lat, rd, er, sok);
    checks++; if (lat !== 3) begin failures++; $display("FAIL hld_latency: got %0d want 3", lat); end
    checks++; if (rd !== 32'hFFFF8001) begin failures++; $display("FAIL hld_signed: got %h want ffff8001", rd); end
    run_req(1'b0, 2'b01, 1'b1, 32'h0001_0005, 32'h0, 1'b0, lat, rd, er, sok);
    checks++; if (rd !== 32'h00008001) begin failures++; $display("FAIL hld_unsigned: got %h want 00008001", rd); end
  endtask

  task automatic test_err();
    int lat; logic [31:0] rd; logic er; bit sok;
    log_a.delete(); log_d.delete();
    run_req(1'b1, 2'b10, 1'b0, 32'h0001_FFFE, 32'h11223344, 1'b0, lat, rd, er, sok);
    checks++; if (lat !== 1) begin failures++; $display("FAIL err_range_latency: got %0d want 1", lat); end
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_range_flag: got %b want 1", er); end
    checks++; if (log_a.size() !== 0) begin failures++; $display("FAIL err_range_writes: got %0d want 0", log_a.size()); end
    run_req(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 1'b0, lat, rd, er, sok);
    checks++; if (lat !== 1) begin failures++; $display("FAIL err_size_latency: got %0d want 1", lat); end
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_size_flag: got %b want 1", er); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err_size_rdata: got %h want 0", rd); end
    run_req(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, lat, rd, er, sok);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL err_wrap_flag: got %b want 1", er); end
    mem[17'h1FFFC] = 8'h01; mem[17'h1FFFD] = 8'h02; mem[17'h1FFFE] = 8'h03; mem[17'h1FFFF] = 8'h04;
    run_req(1'b0, 2'b10, 1'b0, 32'h0001_FFFC, 32'h0, 1'b0, lat, rd, er, sok);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL edge_ok_flag: got %b want 0", er); end
    checks++; if (rd !== 32'h04030201) begin failures++; $display("FAIL edge_ok_rdata: got %h want 04030201", rd); end
    checks++; if (log_a.size() !== 0) begin failures++; $display("FAIL err_total_writes: got %0d want 0", log_a.size()); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er; bit sok;
    mem[17'h10010] = 8'h11; mem[17'h10011] = 8'h22; mem[17'h10012] = 8'h33; mem[17'h10013] = 8'h44;
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.uns = 1'b0;
    bus.addr = 32'h0001_0010; bus.wdata = 32'hAABBCCDD;
    @(posedge clk); @(negedge clk);
    checks++; if (bus.mem_wd !== 32'hDD) begin failures++; $display("FAIL rmid_wd0: got %h want dd", bus.mem_wd); end
    @(posedge clk); @(negedge clk);
    checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL rmid_we1: got %b want 1", bus.mem_we); end
    checks++; if (bus.mem_a !== 32'h0001_0011) begin failures++; $display("FAIL rmid_a1: got %h want 00010011", bus.mem_a); end
    checks++; if (bus.mem_wd !== 32'hCC) begin failures++; $display("FAIL rmid_wd1: got %h want cc", bus.mem_wd); end
    rst_n = 1'b0; bus.req = 1'b0;
    #1;
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rmid_we_drop: got %b want 0", bus.mem_we); end
    checks++; if (bus.mem_a !== 32'h0) begin failures++; $display("FAIL rmid_a_drop: got %h want 0", bus.mem_a); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (mem[17'h10010] !== 8'hDD) begin failures++; $display("FAIL rmid_mem0: got %h want dd", mem[17'h10010]); end
    checks++; if (mem[17'h10011] !== 8'h22) begin failures++; $display("FAIL rmid_mem1: got %h want 22", mem[17'h10011]); end
    checks++; if (mem[17'h10012] !== 8'h33) begin failures++; $display("FAIL rmid_mem2: got %h want 33", mem[17'h10012]); end
    checks++; if (mem[17'h10013] !== 8'h44) begin failures++; $display("FAIL rmid_mem3: got %h want 44", mem[17'h10013]); end
    run_req(1'b0, 2'b00, 1'b0, 32'h0001_0010, 32'h0, 1'b0, lat, rd, er, sok);
    checks++; if (lat !== 2) begin failures++; $display("FAIL rmid_next_latency: got %0d want 2", lat); end
    checks++; if (rd !== 32'hFFFFFFDD) begin failures++; $display("FAIL rmid_next_rdata: got %h want ffffffdd", rd); end
    run_req(1'b0, 2'b01, 1'b1, 32'h0001_0011, 32'h0, 1'b0, lat, rd, er, sok);
    checks++; if (rd !== 32'h00003322) begin failures++; $display("FAIL rmid_half_rdata: got %h want 00003322", rd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er; bit sok;
    int d1, d2; logic [31:0] r1, r2;
    mem[17'h10020] = 8'h7F; mem[17'h10021] = 8'h90;
    d1 = 0; d2 = 0; r1 = '0; r2 = '0;
    bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b00; bus.uns = 1'b0;
    bus.addr = 32'h0001_0020; bus.wdata = '0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.done && d1 == 0) begin
        d1 = i; r1 = bus.rdata; bus.addr = 32'h0001_0021;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL b2b_stall_done: got %b want 0", bus.stall); end
      end else if (bus.done) begin
        d2 = i; r2 = bus.rdata;
        break;
      end
    end
    bus.req = 1'b0;
    $display("txn back_to_back done1=%0d rdata1=%h done2=%0d rdata2=%h", d1, r1, d2, r2);
    @(posedge clk); @(negedge clk);
    checks++; if (d1 !== 2) begin failures++; $display("FAIL b2b_first_done: got %0d want 2", d1); end
    checks++; if (d2 !== 5) begin failures++; $display("FAIL b2b_second_done: got %0d want 5", d2); end
    checks++; if (r1 !== 32'h0000007F) begin failures++; $display("FAIL b2b_rdata1: got %h want 0000007f", r1); end
    checks++; if (r2 !== 32'hFFFFFF90) begin failures++; $display("FAIL b2b_rdata2: got %h want ffffff90", r2); end
    run_req(1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0, 1'b1, lat, rd, er, sok);
    checks++; if (lat !== 5) begin failures++; $display("FAIL drop_latency: got %0d want 5", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL drop_rdata: got %h want deadbeef", rd); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL drop_no_repeat: got %b want 0", bus.done); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
